apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that converts a simple valid/ready request/response interface into APB3 transfers (PSEL/PENABLE/PREADY/PSLVERR).
- Sits between an internal controller (debug port, boot sequencer, DMA config engine) and the APB peripheral bus that hosts the timer and other slaves.
- Adds a bounded wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/apb_master_pkg.sv | 25 ++
 rtl/apb_master_bridge_if.sv | 42 ++++
 rtl/apb_master_bridge.sv | 115 +++++++++++
 tb/tb_apb_master_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
// The bridge defines its request struct locally because the address width is a module parameter.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_resp_t;

    // Wait-counter width: enough to hold the limit itself, never less than one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Requester handshake plus APB3 bus signals of the bridge.
// The master modport is the bridge's view; the slave modport is the requester/peripheral side.
interface apb_master_bridge_if
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
);

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_we_i;
    logic [APB_DATA_WIDTH-1:0] req_wdata_i;
    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic [APB_DATA_WIDTH-1:0] resp_rdata_o;
    logic                      resp_err_o;
    logic                      resp_timeout_o;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
               PRDATA, PREADY, PSLVERR,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_timeout_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, resp_ready_i,
               PRDATA, PREADY, PSLVERR,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_timeout_o,
               PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready request in, APB transfer out,
// registered response with a bounded wait-state timeout.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    apb_master_bridge_if.master bus
);

    localparam int unsigned      CNT_W     = wait_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      we;
        logic [APB_DATA_WIDTH-1:0] wdata;
    } apb_req_t;

    state_e           state;
    apb_req_t         req;
    apb_resp_t        resp;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             limit_hit;
    logic             req_ready;
    logic             resp_valid;
    logic             psel;
    logic             penable;

    always_comb begin
        wait_cnt_next = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
        limit_hit     = (TIMEOUT_CYCLES != 0) && (wait_cnt_next == CNT_LIMIT);
    end

    // The latched request doubles as the APB address/data registers, so they hold between transfers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            req        <= '0;
            resp       <= '0;
            wait_cnt   <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready && bus.req_valid_i) begin
                        req.addr  <= bus.req_addr_i;
                        req.we    <= bus.req_we_i;
                        req.wdata <= bus.req_we_i ? bus.req_wdata_i : '0;
                        wait_cnt  <= '0;
                        req_ready <= 1'b0;
                        psel      <= 1'b1;
                        state     <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        resp.rdata   <= req.we ? '0 : bus.PRDATA;
                        resp.err     <= bus.PSLVERR;
                        resp.timeout <= 1'b0;
                        psel         <= 1'b0;
                        penable      <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt_next;
                        if (limit_hit) begin
                            resp.rdata   <= '0;
                            resp.err     <= 1'b1;
                            resp.timeout <= 1'b1;
                            psel         <= 1'b0;
                            penable      <= 1'b0;
                            resp_valid   <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        resp       <= '0;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o    = req_ready;
    assign bus.resp_valid_o   = resp_valid;
    assign bus.resp_rdata_o   = resp.rdata;
    assign bus.resp_err_o     = resp.err;
    assign bus.resp_timeout_o = resp.timeout;
    assign bus.PADDR          = req.addr;
    assign bus.PWRITE         = req.we;
    assign bus.PWDATA         = req.wdata;
    assign bus.PSEL           = psel;
    assign bus.PENABLE        = penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction-timeline model checked every cycle,
// directed transfers with literal expectations, then randomized traffic.
module tb_apb_master_bridge;

    localparam int unsigned AW = 12;
    localparam int          TO = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    always #5 HCLK = ~HCLK;

    apb_master_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a transfer is described by cycles elapsed since its handshake (m_k) and its ACCESS length.
    bit          m_ready = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_k     = 0;
    int          m_w     = 0;
    int          m_L     = 0;
    logic [AW-1:0] m_addr  = '0;
    logic        m_we    = 1'b0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic        m_to    = 1'b0;

    // Stimulus knobs
    int          d_valid_mode = 2;
    bit          d_fixed      = 1'b0;
    logic [AW-1:0] d_addr     = '0;
    logic        d_we         = 1'b0;
    logic [31:0] d_wdata      = '0;
    int          d_waits      = -1;
    int          d_slverr     = -1;
    bit          d_prd_fix    = 1'b0;
    logic [31:0] d_prdata     = '0;
    int          d_rr_delay   = -1;

    // Observations of the DUT for literal checks
    bit          hs_evt    = 1'b0;
    int          obs_hs    = 0;
    int          obs_lat   = 0;
    int          obs_pen   = 0;
    int          obs_rv    = 0;
    logic [31:0] obs_rdata = '0;
    logic [31:0] obs_pwdata = '0;
    logic        obs_err   = 1'b0;
    logic        obs_to    = 1'b0;
    logic        obs_pwrite = 1'b0;
    logic [AW-1:0] obs_paddr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit e_psel;
        bit e_pen;
        bit e_rv;
        e_psel = m_busy && (m_k >= 1) && (m_k <= 1 + m_L);
        e_pen  = m_busy && (m_k >= 2) && (m_k <= 1 + m_L);
        e_rv   = m_busy && (m_k >= 2 + m_L);
        chk("req_ready", 32'(bus.req_ready_o), 32'(m_ready));
        chk("psel", 32'(bus.PSEL), 32'(e_psel));
        chk("penable", 32'(bus.PENABLE), 32'(e_pen));
        chk("resp_valid", 32'(bus.resp_valid_o), 32'(e_rv));
        chk("paddr", 32'(bus.PADDR), 32'(m_addr));
        chk("pwrite", 32'(bus.PWRITE), 32'(m_we));
        chk("pwdata", bus.PWDATA, m_wdata);
        if (e_rv) begin
            chk("resp_rdata", bus.resp_rdata_o, m_rdata);
            chk("resp_err", 32'(bus.resp_err_o), 32'(m_err));
            chk("resp_timeout", 32'(bus.resp_timeout_o), 32'(m_to));
        end
        if (bus.PENABLE) begin
            obs_pen++;
            if (obs_pen == 1) begin
                obs_paddr  = bus.PADDR;
                obs_pwrite = bus.PWRITE;
                obs_pwdata = bus.PWDATA;
            end
        end
        if (bus.resp_valid_o) begin
            obs_rv++;
            if (obs_lat < 0) begin
                obs_lat   = cyc - obs_hs;
                obs_rdata = bus.resp_rdata_o;
                obs_err   = bus.resp_err_o;
                obs_to    = bus.resp_timeout_o;
            end
        end
    endtask

    task automatic drive();
        bit in_acc;
        bit rdy;
        case (d_valid_mode)
            0:       bus.req_valid_i = 1'($urandom_range(0, 1));
            1:       bus.req_valid_i = 1'b1;
            default: bus.req_valid_i = 1'b0;
        endcase
        if (d_fixed) begin
            bus.req_addr_i  = d_addr;
            bus.req_we_i    = d_we;
            bus.req_wdata_i = d_wdata;
        end else begin
            bus.req_addr_i  = AW'($urandom);
            bus.req_we_i    = 1'($urandom_range(0, 1));
            bus.req_wdata_i = $urandom;
        end
        in_acc = m_busy && (m_k >= 2) && (m_k <= 1 + m_L);
        if (in_acc) begin
            rdy         = (m_k - 2 == m_w);
            bus.PREADY  = rdy;
            bus.PRDATA  = d_prd_fix ? d_prdata : $urandom;
            bus.PSLVERR = (d_slverr < 0) ? 1'($urandom_range(0, 1)) : 1'(d_slverr);
            if (rdy) begin
                m_rdata = m_we ? 32'h0 : bus.PRDATA;
                m_err   = bus.PSLVERR;
                m_to    = 1'b0;
            end
        end else begin
            // Slave inputs outside ACCESS are noise the bridge must ignore
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom_range(0, 1));
        end
        if (m_busy && (m_k >= 2 + m_L))
            bus.resp_ready_i = (d_rr_delay < 0) ? 1'($urandom_range(0, 1))
                                                : 1'(m_k - (2 + m_L) >= d_rr_delay);
        else
            bus.resp_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic update();
        hs_evt = 1'b0;
        if (!m_busy) begin
            if (m_ready && bus.req_valid_i) begin
                m_addr  = bus.req_addr_i;
                m_we    = bus.req_we_i;
                m_wdata = bus.req_we_i ? bus.req_wdata_i : 32'h0;
                m_w     = (d_waits < 0) ? int'($urandom_range(0, 5)) : d_waits;
                if (m_w < TO) begin
                    m_L = m_w + 1;
                end else begin
                    m_L     = TO;
                    m_rdata = 32'h0;
                    m_err   = 1'b1;
                    m_to    = 1'b1;
                end
                m_busy  = 1'b1;
                m_k     = 1;
                m_ready = 1'b0;
                hs_evt  = 1'b1;
                obs_hs  = cyc;
                obs_lat = -1;
                obs_pen = 0;
                obs_rv  = 0;
            end else begin
                m_ready = 1'b1;
            end
        end else if ((m_k >= 2 + m_L) && bus.resp_ready_i) begin
            m_busy  = 1'b0;
            m_ready = 1'b1;
        end else begin
            m_k++;
        end
    endtask

    task automatic step();
        compare();
        drive();
        @(posedge HCLK);
        update();
        #1;
        cyc++;
    endtask

    task automatic run_one(input logic [AW-1:0] a, input logic we, input logic [31:0] wd,
                           input int waits, input int slverr, input logic [31:0] prd,
                           input int rr_delay, input bit hold_valid);
        int n;
        d_fixed = 1'b1; d_addr = a; d_we = we; d_wdata = wd;
        d_waits = waits; d_slverr = slverr; d_prd_fix = 1'b1; d_prdata = prd;
        d_rr_delay = rr_delay; d_valid_mode = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs_evt && n < 20);
        chk("handshake_seen", 32'(hs_evt), 32'd1);
        d_valid_mode = hold_valid ? 1 : 2;
        n = 0;
        while (m_busy && n < 60) begin
            step();
            n++;
        end
        chk("transfer_done", 32'(m_busy), 32'd0);
        d_valid_mode = 2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_we_i     = 1'b0;
        bus.req_wdata_i  = '0;
        bus.resp_ready_i = 1'b0;
        bus.PRDATA       = '0;
        bus.PREADY       = 1'b0;
        bus.PSLVERR      = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_paddr", 32'(bus.PADDR), 32'd0);
        HRESETn = 1'b1;

        // Zero-wait write
        run_one(12'h008, 1'b1, 32'h0000_0005, 0, 0, 32'hFFFF_FFFF, 0, 1'b0);
        chk("wr_latency", 32'(obs_lat), 32'd3);
        chk("wr_pen_cycles", 32'(obs_pen), 32'd1);
        chk("wr_paddr", 32'(obs_paddr), 32'h008);
        chk("wr_pwrite", 32'(obs_pwrite), 32'd1);
        chk("wr_pwdata", obs_pwdata, 32'h0000_0005);
        chk("wr_rdata", obs_rdata, 32'h0);
        chk("wr_err", 32'(obs_err), 32'd0);

        // Read with 3 wait states
        run_one(12'h000, 1'b0, 32'hCAFE_F00D, 3, 0, 32'h1234_5678, 0, 1'b0);
        chk("rd3_pen_cycles", 32'(obs_pen), 32'd4);
        chk("rd3_latency", 32'(obs_lat), 32'd6);
        chk("rd3_rdata", obs_rdata, 32'h1234_5678);
        chk("rd3_pwdata_zero", obs_pwdata, 32'h0);

        // Slave error
        run_one(12'h044, 1'b0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0, 1'b0);
        chk("slverr_err", 32'(obs_err), 32'd1);
        chk("slverr_timeout", 32'(obs_to), 32'd0);
        chk("slverr_rdata", obs_rdata, 32'hDEAD_BEEF);

        // Timeout: PREADY never rises
        run_one(12'h100, 1'b0, 32'h0, 100, 0, 32'h5555_AAAA, 0, 1'b0);
        chk("to_pen_cycles", 32'(obs_pen), 32'd4);
        chk("to_latency", 32'(obs_lat), 32'd6);
        chk("to_err", 32'(obs_err), 32'd1);
        chk("to_timeout", 32'(obs_to), 32'd1);
        chk("to_rdata", obs_rdata, 32'h0);

        // PREADY on the 4th ACCESS cycle wins over the limit
        run_one(12'h104, 1'b0, 32'h0, 3, 0, 32'hA5A5_0F0F, 0, 1'b0);
        chk("edge_timeout", 32'(obs_to), 32'd0);
        chk("edge_err", 32'(obs_err), 32'd0);
        chk("edge_rdata", obs_rdata, 32'hA5A5_0F0F);

        // Response backpressure with request valid held high
        run_one(12'h0F0, 1'b0, 32'h0, 0, 0, 32'h0BEE_F00D, 5, 1'b1);
        chk("bp_rv_cycles", 32'(obs_rv), 32'd6);
        chk("bp_rdata", obs_rdata, 32'h0BEE_F00D);

        // Async reset while the slave is stalling
        d_fixed = 1'b1; d_addr = 12'h123; d_we = 1'b0; d_wdata = 32'h0;
        d_waits = 100; d_slverr = 0; d_prd_fix = 1'b0; d_rr_delay = 0; d_valid_mode = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (!hs_evt && n < 20);
        chk("rst_hs_seen", 32'(hs_evt), 32'd1);
        d_valid_mode = 2;
        step();
        step();
        bus.req_valid_i = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.PSEL), 32'd0);
        chk("arst_penable", 32'(bus.PENABLE), 32'd0);
        chk("arst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("arst_paddr", 32'(bus.PADDR), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready_o), 32'd0);
        @(posedge HCLK);
        #1;
        chk("arst_hold_psel", 32'(bus.PSEL), 32'd0);
        HRESETn = 1'b1;
        m_busy = 1'b0; m_ready = 1'b0; m_k = 0;
        m_addr = '0; m_we = 1'b0; m_wdata = '0;
        cyc++;
        run_one(12'h3FC, 1'b0, 32'h0, 1, 0, 32'h0BAD_F00D, 0, 1'b0);
        chk("post_rst_rdata", obs_rdata, 32'h0BAD_F00D);
        chk("post_rst_latency", 32'(obs_lat), 32'd4);

        // Randomized traffic
        d_fixed = 1'b0; d_waits = -1; d_slverr = -1; d_prd_fix = 1'b0;
        d_rr_delay = -1; d_valid_mode = 0;
        repeat (800) step();
        d_valid_mode = 2;
        n = 0;
        while (m_busy && n < 60) begin
            step();
            n++;
        end
        chk("random_drain", 32'(m_busy), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
